// File: rtl/moo_ghash_pkg.sv
// rtl/moo_ghash_pkg.sv - shared GHASH constants, state encoding and byte-mask helpers
package moo_ghash_pkg;

  // Top byte of the GCM reduction constant (x^128 = x^7 + x^2 + x + 1, reflected order)
  localparam logic [7:0] GCM_R = 8'hE1;

  // One-hot controller states
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_MUL  = 4'b0010,
    ST_LEN  = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  // Keep-mask for a block holding nbytes valid bytes (byte 0 = [127:120]); 0 means a full block
  function automatic logic [127:0] byte_mask(input logic [4:0] nbytes);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (nbytes == 5'd0 || 5'(i) < nbytes) begin
        m[127-8*i -: 8] = 8'hFF;
      end
    end
    return m;
  endfunction

  // 64-bit add that sticks at all-ones instead of wrapping
  function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? {64{1'b1}} : s[63:0];
  endfunction

endpackage

// File: rtl/gfm128_dig.sv
// rtl/gfm128_dig.sv - combinational GF(2^128) digit step: folds DIGIT_W bits of H, MSB first
module gfm128_dig
  import moo_ghash_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic [127:0]       vi,
  input  logic [127:0]       zi,
  input  logic [DIGIT_W-1:0] hd,
  output logic [127:0]       vo,
  output logic [127:0]       zo
);

  logic [127:0] w_v;
  logic [127:0] w_z;

  // Conditionally accumulate V, then multiply V by x with reduction, once per H bit
  always_comb begin
    w_v = vi;
    w_z = zi;
    for (int i = DIGIT_W - 1; i >= 0; i--) begin
      if (hd[i]) begin
        w_z = w_z ^ w_v;
      end
      w_v = {1'b0, w_v[127:1]} ^ (w_v[0] ? {GCM_R, 120'd0} : 128'd0);
    end
    vo = w_v;
    zo = w_z;
  end

endmodule

// File: rtl/moo_ghash_stream.sv
// rtl/moo_ghash_stream.sv - streaming digit-serial GHASH engine; MOO_GHASH_LEN_EN appends the length block
module moo_ghash_stream
  import moo_ghash_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ghash_clr,
  input  logic         h_load,
  input  logic [127:0] h,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [4:0]   in_bytes,
  input  logic         in_kind,
  input  logic         in_last,
  output logic         ghash_vld,
  output logic [127:0] ghash,
  output logic         busy,
  output logic         h_err
);

  localparam int N     = 128 / DIGIT_W;
  localparam int CNT_W = $clog2(N);

  if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 ||
        DIGIT_W == 8 || DIGIT_W == 16 || DIGIT_W == 32)) begin : g_bad_digit_w
    $error("moo_ghash_stream: DIGIT_W must be one of 1,2,4,8,16,32");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [127:0]       r_y;
  logic [127:0]       r_h;
  logic [127:0]       r_v;
  logic [127:0]       r_z;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;
  logic               r_h_err;

  logic [127:0]       w_vo;
  logic [127:0]       w_zo;
  logic [127:0]       w_seed;
  logic [127:0]       w_block;
  logic [6:0]         w_hidx;
  logic [DIGIT_W-1:0] w_hd;
  logic               w_cnt_last;
  logic               w_stepping;
  logic               w_accept;

`ifdef MOO_GHASH_LEN_EN
  logic [63:0]        r_aad_bits;
  logic [63:0]        r_txt_bits;
  logic [63:0]        w_add_bits;
  assign w_add_bits = {56'd0, (in_bytes == 5'd0) ? 5'd16 : in_bytes, 3'd0};
`else
  logic               w_unused_kind;
  assign w_unused_kind = in_kind;
`endif

  assign w_hidx     = 7'(127 - int'(r_cnt) * DIGIT_W);
  assign w_hd       = r_h[w_hidx -: DIGIT_W];
  assign w_cnt_last = (r_cnt == CNT_W'(N - 1));
  assign w_stepping = (r_state == ST_MUL) || (r_state == ST_LEN);
  assign w_accept   = in_valid & in_ready & ~ghash_clr;
  // A chained accept folds into the product finishing this cycle rather than the stale Y
  assign w_seed     = (r_state == ST_IDLE) ? r_y : w_zo;
  assign w_block    = in_data & byte_mask(in_bytes);

  assign ghash_vld  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign ghash      = r_y;
  assign h_err      = r_h_err;

  gfm128_dig #(.DIGIT_W(DIGIT_W)) u_dig (
    .vi (r_v),
    .zi (r_z),
    .hd (w_hd),
    .vo (w_vo),
    .zo (w_zo)
  );

  // Controller state register; clear aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst || ghash_clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and block-input handshake
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        if (w_cnt_last) begin
          if (!r_last) begin
            in_ready    = 1'b1;
            w_state_nxt = in_valid ? ST_MUL : ST_IDLE;
          end else begin
`ifdef MOO_GHASH_LEN_EN
            w_state_nxt = ST_LEN;
`else
            w_state_nxt = ST_DONE;
`endif
          end
        end
      end
      ST_LEN: begin
        if (w_cnt_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Multiplier datapath, accumulator, subkey and length counters
  always_ff @(posedge clk) begin
    if (rst || ghash_clr) begin
      r_y     <= '0;
      r_v     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_h_err <= 1'b0;
      if (rst) begin
        r_h <= '0;
      end
`ifdef MOO_GHASH_LEN_EN
      r_aad_bits <= '0;
      r_txt_bits <= '0;
`endif
    end else begin
      // H may only change while idle and not starting a block, so a product never sees a mixed key
      if (h_load) begin
        if (r_state == ST_IDLE && !w_accept) begin
          r_h <= h;
        end else begin
          r_h_err <= 1'b1;
        end
      end

      if (w_stepping) begin
        r_v   <= w_vo;
        r_z   <= w_zo;
        r_cnt <= r_cnt + 1'b1;
        if (w_cnt_last) begin
          r_y <= w_zo;
        end
      end

      if (w_accept) begin
        r_v    <= w_seed ^ w_block;
        r_z    <= '0;
        r_cnt  <= '0;
        r_last <= in_last;
`ifdef MOO_GHASH_LEN_EN
        if (in_kind) begin
          r_txt_bits <= sat_add64(r_txt_bits, w_add_bits);
        end else begin
          r_aad_bits <= sat_add64(r_aad_bits, w_add_bits);
        end
`endif
      end

`ifdef MOO_GHASH_LEN_EN
      // Last user block done: seed the length-block multiply from the freshly finished Y
      if (r_state == ST_MUL && w_cnt_last && r_last) begin
        r_v   <= w_zo ^ {r_aad_bits, r_txt_bits};
        r_z   <= '0;
        r_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_moo_ghash_stream.sv
// tb/tb_moo_ghash_stream.sv - scoreboard bench for moo_ghash_stream (directed GHASH vectors)
`timescale 1ns/1ps
module tb_moo_ghash_stream;

  localparam int DIGIT_W = 8;
  localparam int N       = 128 / DIGIT_W;
`ifdef MOO_GHASH_LEN_EN
  localparam int LAT     = 2 * N + 1;
`else
  localparam int LAT     = N + 1;
`endif

  localparam logic [127:0] T1    = 128'h1234567890abcdef1234567890abcdef;
  localparam logic [127:0] H_ONE = {8'h80, 120'd0};
  localparam logic [127:0] H_X   = {8'h40, 120'd0};
  localparam logic [127:0] H3    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C3    = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] Y3    = 128'h5e2ec746917062882c85b0685353deb7;
  localparam logic [127:0] G3    = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] LEN3  = 128'h00000000000000000000000000000080;
  localparam logic [127:0] H5    = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] B4_0  = 128'h42831ec2217774244b7221b784d0d49c;
  localparam logic [127:0] B4_1  = 128'he3aa212f2c02a4e035c17e2329aca12e;
  localparam logic [127:0] B4_2  = 128'h21d514b25466931c7d8f6a5aac84aa05;
  localparam logic [127:0] M5    = {40'hffffffffff, 88'd0};

  logic         clk = 1'b0;
  logic         rst;
  logic         ghash_clr;
  logic         h_load;
  logic [127:0] h;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [4:0]   in_bytes;
  logic         in_kind;
  logic         in_last;
  logic         ghash_vld;
  logic [127:0] ghash;
  logic         busy;
  logic         h_err;

  moo_ghash_stream #(.DIGIT_W(DIGIT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ghash_clr (ghash_clr),
    .h_load    (h_load),
    .h         (h),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_kind   (in_kind),
    .in_last   (in_last),
    .ghash_vld (ghash_vld),
    .ghash     (ghash),
    .busy      (busy),
    .h_err     (h_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] val;
    int           at;
    string        name;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [127:0] rev128(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // Reference product: plain carry-less multiply in natural bit order, then reduce
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ar;
    logic [127:0] br;
    logic [254:0] p;
    ar = rev128(a);
    br = rev128(b);
    p  = '0;
    for (int i = 0; i < 128; i++) begin
      if (ar[i]) p = p ^ (255'(br) << i);
    end
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) begin
        p[i]       = 1'b0;
        p[i-128]   = p[i-128] ^ 1'b1;
        p[i-127]   = p[i-127] ^ 1'b1;
        p[i-126]   = p[i-126] ^ 1'b1;
        p[i-121]   = p[i-121] ^ 1'b1;
      end
    end
    return rev128(p[127:0]);
  endfunction

  function automatic logic [127:0] fold(input logic [127:0] y, input logic [127:0] x,
                                        input logic [127:0] hh);
    return gf_mul(y ^ x, hh);
  endfunction

  // Finishes a message model: appends the length block only when the engine does so itself
  function automatic logic [127:0] finish(input logic [127:0] y, input logic [63:0] aad,
                                          input logic [63:0] txt, input logic [127:0] hh);
`ifdef MOO_GHASH_LEN_EN
    return fold(y, {aad, txt}, hh);
`else
    if (aad == 64'd0 && txt == 64'd0 && hh == 128'd0) return '0;
    return y;
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [127:0] v, input int at, input string nm);
    exp_t e;
    e.val  = v;
    e.at   = at;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: every ghash_vld pulse must match the oldest expected result and its cycle
  always @(negedge clk) begin
    if (!rst && ghash_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ghash_vld: got pulse at cycle %0d with ghash %h expected none", cyc, ghash);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_ghash"}, ghash, e.val);
        chk({e.name, "_cycle"}, 128'(cyc), 128'(e.at));
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [4:0] nb, input logic kind,
                      input logic last, output int acc);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    in_bytes = nb;
    in_kind  = kind;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 4 * LAT) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 after %0d cycles expected 1", w);
    end
    acc = cyc;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_h(input logic [127:0] v);
    h_load = 1'b1;
    h      = v;
    @(negedge clk);
    h_load = 1'b0;
  endtask

  task automatic clr();
    ghash_clr = 1'b1;
    @(negedge clk);
    ghash_clr = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 8 * LAT) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending results busy %0d expected 0 and 0", exp_q.size(), busy);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3;
    logic [127:0] y;

    rst = 1'b1; ghash_clr = 1'b0; h_load = 1'b0; h = '0;
    in_valid = 1'b0; in_data = '0; in_bytes = 5'd0; in_kind = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_ghash", ghash, 128'd0);
    chk("reset_vld", 128'(ghash_vld), 128'd0);
    chk("reset_h_err", 128'(h_err), 128'd0);

    // 1: H = one, result is the block itself
    load_h(H_ONE);
    clr();
    send(T1, 5'd16, 1'b0, 1'b1, a1);
    idle();
`ifdef MOO_GHASH_LEN_EN
    push(128'h1234567890abcd6f1234567890abcdef, a1 + LAT, "t1_one");
`else
    push(T1, a1 + LAT, "t1_one");
`endif
    wait_done();

    // 2: x^127 * x reduces to x^7+x^2+x+1
    load_h(H_X);
    clr();
    send(128'd1, 5'd16, 1'b1, 1'b1, a1);
    idle();
`ifdef MOO_GHASH_LEN_EN
    push(128'h70800000000000000000000000000040, a1 + LAT, "t2_reduce");
`else
    push({8'hE1, 120'd0}, a1 + LAT, "t2_reduce");
`endif
    wait_done();

    // 3: GCM reference vector, one ciphertext block
    load_h(H3);
    clr();
`ifdef MOO_GHASH_LEN_EN
    send(C3, 5'd16, 1'b1, 1'b1, a1);
    idle();
    push(G3, a1 + LAT, "t3_gcm");
    repeat (N) @(negedge clk);
    chk("t3_intermediate_y", ghash, Y3);
`else
    send(C3, 5'd16, 1'b1, 1'b0, a1);
    send(LEN3, 5'd16, 1'b1, 1'b1, a2);
    idle();
    push(G3, a2 + LAT, "t3_gcm");
    chk("t3_intermediate_y", ghash, Y3);
    chk("t3_chain_gap", 128'(a2 - a1), 128'(N));
`endif
    wait_done();

    // 4: three blocks with in_valid held
    clr();
    send(B4_0, 5'd16, 1'b1, 1'b0, a1);
    send(B4_1, 5'd16, 1'b1, 1'b0, a2);
    send(B4_2, 5'd16, 1'b1, 1'b1, a3);
    idle();
    chk("t4_gap01", 128'(a2 - a1), 128'(N));
    chk("t4_gap12", 128'(a3 - a2), 128'(N));
    y = fold(128'd0, B4_0, H3);
    y = fold(y, B4_1, H3);
    y = fold(y, B4_2, H3);
    push(finish(y, 64'd0, 64'd384, H3), a3 + LAT, "t4_three");
    wait_done();

    // 5: partial block is masked to its valid bytes
    load_h(H5);
    clr();
    send({128{1'b1}}, 5'd5, 1'b1, 1'b1, a1);
    idle();
    push(finish(fold(128'd0, M5, H5), 64'd0, 64'd40, H5), a1 + LAT, "t5_partial");
    wait_done();

    // 5b: in_bytes=0 means a full block; AAD then partial text
    clr();
    send(B4_0, 5'd0, 1'b0, 1'b0, a1);
    send({128{1'b1}}, 5'd5, 1'b1, 1'b1, a2);
    idle();
    y = fold(128'd0, B4_0, H5);
    y = fold(y, M5, H5);
    push(finish(y, 64'd128, 64'd40, H5), a2 + LAT, "t5b_aad_txt");
    wait_done();

    // 6: h_load while busy is rejected, clear mid-multiply aborts without a result
    load_h(H_ONE);
    clr();
    send(T1, 5'd16, 1'b1, 1'b1, a1);
    idle();
    h_load = 1'b1;
    h      = H_X;
    @(negedge clk);
    h_load = 1'b0;
    chk("t6_h_err_set", 128'(h_err), 128'd1);
    @(negedge clk);
    @(negedge clk);
    ghash_clr = 1'b1;
    @(negedge clk);
    ghash_clr = 1'b0;
    chk("t6_abort_busy", 128'(busy), 128'd0);
    chk("t6_abort_y", ghash, 128'd0);
    chk("t6_abort_in_ready", 128'(in_ready), 128'd1);
    chk("t6_clr_h_err", 128'(h_err), 128'd0);
    repeat (LAT + 4) @(negedge clk);
    send(T1, 5'd16, 1'b1, 1'b1, a1);
    idle();
`ifdef MOO_GHASH_LEN_EN
    push(128'h1234567890abcdef1234567890abcd6f, a1 + LAT, "t6_h_kept");
`else
    push(T1, a1 + LAT, "t6_h_kept");
`endif
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
